// File: rtl/mod_inv_arbiter.sv
// Round-robin arbiter sharing one 256-bit modular inverter among NREQ requesters.
// Optional macro ZERO_CHECK_EN: zero operands bypass the inverter and return resp_err=1.
module mod_inv_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 256,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   resp_valid,
   output logic [W-1:0]      resp_c,
   output logic              resp_err,
   output logic              busy,
   output logic              inv_rstn,
   output logic [W-1:0]      inv_a,
   output logic              inv_datain,
   input  logic [W-1:0]      inv_c,
   input  logic              inv_done,
   output logic [1:0]        dbg_state
);

   // Handshake: a request transfers on the rising edge where req_valid[i] && req_ready[i];
   // req_ready is only offered in IDLE. resp_valid has no backpressure.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e          state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  g_q;
   logic [NREQ-1:0] resp_valid_q;
   logic [W-1:0]    resp_c_q;
   logic            resp_err_q;
   logic [W-1:0]    inv_a_q;
   logic            inv_datain_q;

   logic [W-1:0]    req_a_arr [NREQ];
   logic [IDW-1:0]  gnt_idx;
   logic [IDW-1:0]  scan_idx;
   logic            gnt_found;
   logic [W-1:0]    gnt_a;
   logic            zero_op;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign req_a_arr[i] = req_a[i*W +: W];
   end

   // Scan from the farthest offset down so the nearest requester at or after ptr wins.
   always_comb begin
      gnt_idx   = ptr_q;
      gnt_found = 1'b0;
      scan_idx  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (req_valid[scan_idx]) begin
            gnt_idx   = scan_idx;
            gnt_found = 1'b1;
         end
      end
   end

   assign gnt_a = req_a_arr[gnt_idx];

`ifdef ZERO_CHECK_EN
   assign zero_op = (gnt_a == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         g_q          <= '0;
         resp_valid_q <= '0;
         resp_c_q     <= '0;
         resp_err_q   <= 1'b0;
         inv_a_q      <= '0;
         inv_datain_q <= 1'b0;
      end else begin
         resp_valid_q <= '0;
         inv_datain_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_found) begin
                  g_q        <= gnt_idx;
                  resp_err_q <= zero_op;
                  if (zero_op) begin
                     resp_c_q     <= '0;
                     resp_valid_q <= NREQ'(1) << gnt_idx;
                     state_q      <= RESP;
                  end else begin
                     inv_a_q      <= gnt_a;
                     inv_datain_q <= 1'b1;
                     state_q      <= ISSUE;
                  end
               end
            end
            ISSUE: state_q <= WAIT;
            WAIT: begin
               if (inv_done) begin
                  resp_c_q     <= inv_c;
                  resp_valid_q <= NREQ'(1) << g_q;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               ptr_q   <= (g_q == IDW'(NREQ - 1)) ? '0 : IDW'(g_q + 1'b1);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
   assign resp_valid = resp_valid_q;
   assign resp_c     = resp_c_q;
   assign resp_err   = resp_err_q;
   assign busy       = (state_q != IDLE);
   assign inv_rstn   = ~rst;
   assign inv_a      = inv_a_q;
   assign inv_datain = inv_datain_q;
   assign dbg_state  = state_q;

endmodule
